pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk_i and rst_i.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the PC loaded on reset.
REQ-003 The block SHALL have parameter STEP, default 4, which is the sequential PC increment.
REQ-004 The block SHALL have port clk_i, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port stall_i, input, 1 bit: freeze the PC and ignore redirects this cycle.
REQ-007 The block SHALL have ports jump_i (input, 1 bit) and jump_addr_i (input, 32 bits): jump redirect request and its target.
REQ-008 The block SHALL have ports branch_i (input, 1 bit) and branch_addr_i (input, 32 bits): taken-branch redirect request and its target.
REQ-009 The block SHALL have port halt_i, input, 1 bit: request to stop fetching.
REQ-010 The block SHALL have port fetch_ready_i, input, 1 bit: the downstream fetch/adder stage accepts pc_o.
REQ-011 The block SHALL have port fetch_valid_o, output, 1 bit: pc_o is a valid fetch address.
REQ-012 The block SHALL have port pc_o, output, 32 bits: current PC, registered; it feeds the PC+STEP adder and the instruction memory.
REQ-013 The block SHALL have port state_o, output, 2 bits: current state, encoded IDLE=0, RUN=1, HALT=2.
REQ-014 The block SHALL have port redirect_cnt_o, output, 16 bits: count of accepted redirects.
REQ-015 The block SHALL have port fault_o, output, 1 bit: sticky misaligned-target fault.

Function
REQ-016 The state machine SHALL leave IDLE for RUN unconditionally on the first clock edge after reset is released.
REQ-017 The state machine SHALL move from RUN to HALT on any edge where halt_i=1 and stall_i=0.
REQ-018 HALT SHALL be left only by reset.
REQ-019 fetch_valid_o SHALL equal (state==RUN) & ~stall_i, combinationally.
REQ-020 In RUN with stall_i=0, the next PC SHALL be chosen with priority jump_i, then branch_i, then sequential.
REQ-021 On jump_i or branch_i in RUN with stall_i=0, pc_o SHALL update to the selected target on the next edge, whatever fetch_ready_i is.
REQ-022 A sequential advance SHALL occur only when fetch_valid_o & fetch_ready_i; the PC then becomes pc_o+STEP, modulo 2^32.
REQ-023 With no sequential advance and no redirect, pc_o SHALL hold its value.
REQ-024 When stall_i=1, pc_o, the state and redirect_cnt_o SHALL hold, and redirects SHALL be dropped; the requester keeps its request asserted.
REQ-025 When halt_i and a redirect arrive in the same cycle, the redirect SHALL be applied and the state SHALL then go to HALT.
REQ-026 Wrap-around SHALL be silent: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag raised.
REQ-027 redirect_cnt_o SHALL increment by 1 on each applied redirect and SHALL saturate at 16'hFFFF.
REQ-028 PC-change latency SHALL be one cycle from the qualifying edge, with no combinational path from jump_addr_i or branch_addr_i to pc_o.

Reset
REQ-029 While rst_i=1, asynchronously: pc_o SHALL be RESET_PC, state_o IDLE, redirect_cnt_o 0, fault_o 0, and fetch_valid_o 0.
REQ-030 Reset asserted mid-operation SHALL abort any pending redirect or advance, and the first valid fetch after release SHALL be RESET_PC.

Configuration
REQ-031 Macro PC_ALIGN_CHECK_EN SHALL select how redirect targets with addr[1:0]!=0 are handled.
REQ-032 With PC_ALIGN_CHECK_EN defined, such a target SHALL not be loaded: fault_o goes to 1 and stays there, the state goes to HALT, pc_o keeps its old value, and the counter is not incremented.
REQ-033 Without PC_ALIGN_CHECK_EN, target bits [1:0] SHALL be forced to 0 before loading, and fault_o SHALL be tied to 0.

Verification
REQ-034 Reset, release, fetch_ready_i=1 for 4 cycles -> state_o goes IDLE then RUN, and pc_o runs 0,0,4,8,C.
REQ-035 At PC 0x10, assert jump_i with 0x100 and branch_i with 0x200 together -> pc_o=0x100 next cycle, redirect_cnt_o=1.
REQ-036 stall_i=1 with branch_i to 0x40, for 3 cycles -> pc_o and the counter are unchanged and fetch_valid_o=0; release with branch still asserted -> pc_o=0x40.
REQ-037 Load 0xFFFF_FFFC via jump, then fetch_ready_i=1 -> pc_o=0x0000_0000, fault_o=0.
REQ-038 Jump to 0x102 -> with PC_ALIGN_CHECK_EN, fault_o=1, state_o=HALT, PC unchanged; without the macro, pc_o=0x100.
REQ-039 rst_i pulse mid-run at PC 0x80 -> pc_o=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program-counter sequencer with IDLE/RUN/HALT control, jump/branch
//            redirects, stall and a saturating redirect counter.
//            Optional macro PC_ALIGN_CHECK_EN: misaligned redirect targets
//            raise a sticky fault and halt (otherwise targets are word-aligned).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          STEP     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        halt_i,
    input  logic        fetch_ready_i,
    output logic        fetch_valid_o,
    output logic [31:0] pc_o,
    output logic [1:0]  state_o,
    output logic [15:0] redirect_cnt_o,
    output logic        fault_o
);

    localparam logic [31:0] c_step = 32'(STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        w_redirect;
    logic [31:0] w_target_raw;
    logic [15:0] w_cnt_inc;

    assign w_redirect    = jump_i | branch_i;
    assign w_target_raw  = jump_i ? jump_addr_i : branch_addr_i;
    assign w_cnt_inc     = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign fetch_valid_o = (r_state == RUN) & ~stall_i;

`ifdef PC_ALIGN_CHECK_EN
    logic r_fault, w_fault_nxt;
    logic w_misaligned;

    assign w_misaligned = |w_target_raw[1:0];
`else
    logic [31:0] w_target;

    // Low bits of a redirect target are dropped rather than trapped.
    assign w_target = w_target_raw & ~32'h3;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
`ifdef PC_ALIGN_CHECK_EN
        w_fault_nxt = r_fault;
`endif
        case (r_state)
            IDLE: w_state_nxt = RUN;
            RUN: begin
                if (!stall_i) begin
                    if (w_redirect) begin
`ifdef PC_ALIGN_CHECK_EN
                        if (w_misaligned) begin
                            w_fault_nxt = 1'b1;
                            w_state_nxt = HALT;
                        end else begin
                            w_pc_nxt  = w_target_raw;
                            w_cnt_nxt = w_cnt_inc;
                        end
`else
                        w_pc_nxt  = w_target;
                        w_cnt_nxt = w_cnt_inc;
`endif
                    end else if (fetch_ready_i) begin
                        w_pc_nxt = r_pc + c_step;
                    end
                    if (halt_i) begin
                        w_state_nxt = HALT;
                    end
                end
            end
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_fault_nxt;
        end
    end

    assign fault_o = r_fault;
`else
    assign fault_o = 1'b0;
`endif

    assign pc_o           = r_pc;
    assign state_o        = r_state;
    assign redirect_cnt_o = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed, table-driven self-checking bench for pc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = 32'h0;
    logic        halt_i = 1'b0;
    logic        fetch_ready_i = 1'b0;
    logic        fetch_valid_o;
    logic [31:0] pc_o;
    logic [1:0]  state_o;
    logic [15:0] redirect_cnt_o;
    logic        fault_o;

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stall_i        (stall_i),
        .jump_i         (jump_i),
        .jump_addr_i    (jump_addr_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .halt_i         (halt_i),
        .fetch_ready_i  (fetch_ready_i),
        .fetch_valid_o  (fetch_valid_o),
        .pc_o           (pc_o),
        .state_o        (state_o),
        .redirect_cnt_o (redirect_cnt_o),
        .fault_o        (fault_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        stall;
        logic        jump;
        logic [31:0] jaddr;
        logic        branch;
        logic [31:0] baddr;
        logic        halt;
        logic        ready;
        logic        exp_fv;
        logic [31:0] exp_pc;
        logic [1:0]  exp_state;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic j, input logic [31:0] ja,
                         input logic b, input logic [31:0] ba, input logic h, input logic r);
        stall_i       = st;
        jump_i        = j;
        jump_addr_i   = ja;
        branch_i      = b;
        branch_addr_i = ba;
        halt_i        = h;
        fetch_ready_i = r;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [31:0] pc, input logic [1:0] st,
                              input logic [15:0] cnt);
        chk({tag, ".pc"}, pc_o, pc);
        chk({tag, ".state"}, {30'd0, state_o}, {30'd0, st});
        chk({tag, ".cnt"}, {16'd0, redirect_cnt_o}, {16'd0, cnt});
    endtask

    // Reset across one edge, release, then take the IDLE->RUN edge.
    task automatic reset_to_run();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    function automatic vec_t mk(logic st, logic j, logic [31:0] ja, logic b, logic [31:0] ba,
                                logic h, logic r, logic fv, logic [31:0] pc, logic [1:0] s,
                                logic [15:0] c);
        vec_t v;
        v.stall = st; v.jump = j; v.jaddr = ja; v.branch = b; v.baddr = ba;
        v.halt = h; v.ready = r; v.exp_fv = fv; v.exp_pc = pc; v.exp_state = s;
        v.exp_cnt = c;
        return v;
    endfunction

    initial begin
        //            st j  jaddr          b  baddr        h  r  fv pc             st cnt
        vecs[0]  = mk(0, 0, 32'h0,         0, 32'h0,       0, 1, 0, 32'h0,         1, 0);
        vecs[1]  = mk(0, 0, 32'h0,         0, 32'h0,       0, 1, 1, 32'h4,         1, 0);
        vecs[2]  = mk(0, 0, 32'h0,         0, 32'h0,       0, 1, 1, 32'h8,         1, 0);
        vecs[3]  = mk(0, 0, 32'h0,         0, 32'h0,       0, 1, 1, 32'hC,         1, 0);
        vecs[4]  = mk(0, 0, 32'h0,         0, 32'h0,       0, 1, 1, 32'h10,        1, 0);
        vecs[5]  = mk(0, 1, 32'h100,       1, 32'h200,     0, 1, 1, 32'h100,       1, 1);
        vecs[6]  = mk(1, 0, 32'h0,         1, 32'h40,      0, 1, 0, 32'h100,       1, 1);
        vecs[7]  = mk(1, 0, 32'h0,         1, 32'h40,      0, 1, 0, 32'h100,       1, 1);
        vecs[8]  = mk(1, 0, 32'h0,         1, 32'h40,      0, 1, 0, 32'h100,       1, 1);
        vecs[9]  = mk(0, 0, 32'h0,         1, 32'h40,      0, 1, 1, 32'h40,        1, 2);
        vecs[10] = mk(0, 0, 32'h0,         0, 32'h0,       0, 0, 1, 32'h40,        1, 2);
        vecs[11] = mk(0, 0, 32'h0,         1, 32'h300,     0, 0, 1, 32'h300,       1, 3);
        vecs[12] = mk(0, 1, 32'hFFFF_FFFC, 0, 32'h0,       0, 0, 1, 32'hFFFF_FFFC, 1, 4);
        vecs[13] = mk(0, 0, 32'h0,         0, 32'h0,       0, 1, 1, 32'h0,         1, 4);
        vecs[14] = mk(1, 0, 32'h0,         0, 32'h0,       1, 1, 0, 32'h0,         1, 4);
        vecs[15] = mk(0, 1, 32'h80,        0, 32'h0,       0, 0, 1, 32'h80,        1, 5);

        // Reset state while rst_i is held.
        #2;
        check_regs("reset", 32'h0, 2'd0, 16'd0);
        chk("reset.fv", {31'd0, fetch_valid_o}, 32'd0);
        chk("reset.fault", {31'd0, fault_o}, 32'd0);
        tick();
        rst_i = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].stall, vecs[i].jump, vecs[i].jaddr, vecs[i].branch,
                  vecs[i].baddr, vecs[i].halt, vecs[i].ready);
            #1;
            chk($sformatf("v%0d.fv", i), {31'd0, fetch_valid_o}, {31'd0, vecs[i].exp_fv});
            tick();
            check_regs($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_state, vecs[i].exp_cnt);
        end
        chk("wrap.fault", {31'd0, fault_o}, 32'd0);

        // Asynchronous reset mid-run at PC 0x80, no clock edge in between.
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        rst_i = 1'b1;
        #1;
        check_regs("async_rst", 32'h0, 2'd0, 16'd0);
        chk("async_rst.fv", {31'd0, fetch_valid_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        #1;
        chk("post_rst.fv_idle", {31'd0, fetch_valid_o}, 32'd0);
        tick();
        chk("post_rst.fv_run", {31'd0, fetch_valid_o}, 32'd1);
        check_regs("post_rst", 32'h0, 2'd1, 16'd0);

        // Misaligned jump target.
        drive(0, 1, 32'h102, 0, 0, 0, 1);
        tick();
`ifdef PC_ALIGN_CHECK_EN
        check_regs("misalign", 32'h0, 2'd2, 16'd0);
        chk("misalign.fault", {31'd0, fault_o}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        check_regs("misalign_hold", 32'h0, 2'd2, 16'd0);
        chk("misalign_hold.fault", {31'd0, fault_o}, 32'd1);
`else
        check_regs("misalign", 32'h100, 2'd1, 16'd1);
        chk("misalign.fault", {31'd0, fault_o}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        check_regs("misalign_next", 32'h104, 2'd1, 16'd1);
`endif

        // Halt with a simultaneous redirect, then HALT ignores everything.
        reset_to_run();
        chk("halt_pre.fault", {31'd0, fault_o}, 32'd0);
        drive(0, 0, 0, 1, 32'h200, 1, 1);
        tick();
        check_regs("halt_redir", 32'h200, 2'd2, 16'd1);
        drive(0, 1, 32'h300, 0, 0, 0, 1);
        #1;
        chk("halted.fv", {31'd0, fetch_valid_o}, 32'd0);
        tick();
        check_regs("halted", 32'h200, 2'd2, 16'd1);

        // Counter saturation.
        reset_to_run();
        drive(0, 1, 32'h4, 0, 0, 0, 1);
        repeat (65535) @(posedge clk_i);
        #1;
        chk("sat.full", {16'd0, redirect_cnt_o}, 32'h0000_FFFF);
        repeat (3) @(posedge clk_i);
        #1;
        chk("sat.hold", {16'd0, redirect_cnt_o}, 32'h0000_FFFF);
        drive(0, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
